// File: rtl/seven_seg_scan.sv
// Scans a 16-bit hex value across four time-multiplexed digits for the seven_seg stage.
// New values are double-buffered and only take effect at a frame boundary, never mid-frame.
module seven_seg_scan #(
    parameter int         CLK_DIV  = 50000,
    parameter logic [3:0] ZERO_NIB = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic        blank_lz,
    output logic [3:0]  display_value,
    output logic [1:0]  display_select,
    output logic        digit_en,
    output logic        load_ack,
    output logic        frame_done
);

    localparam int             PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    digit, digit_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic [15:0]   pending, pending_nxt;
    logic          pend_flag, pend_flag_nxt;
    logic [3:0]    display_value_nxt;
    logic          digit_en_nxt;
    logic          load_ack_nxt;
    logic          frame_done_nxt;
    logic          tick;
    logic          frame_wrap;

    function automatic logic [3:0] nibble_at(input logic [15:0] s, input logic [1:0] d);
        return s[{d, 2'b00} +: 4];
    endfunction

    // A digit is dark only when it and every more significant digit hold ZERO_NIB;
    // digit 0 always lights so a zero value still shows a single 0.
    function automatic logic lz_digit_en(input logic [15:0] s, input logic [1:0] d,
                                         input logic blank);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(d) && s[i*4 +: 4] != ZERO_NIB)
                upper_zero = 1'b0;
        end
        return !(blank && (d != 2'd0) && upper_zero);
    endfunction

    assign tick           = (presc == PRESC_MAX);
    assign frame_wrap     = tick && (digit == 2'd3);
    assign display_select = digit;

    always_comb begin
        presc_nxt         = presc;
        digit_nxt         = digit;
        shadow_nxt        = shadow;
        pending_nxt       = pending;
        pend_flag_nxt     = pend_flag;
        display_value_nxt = display_value;
        digit_en_nxt      = digit_en;
        load_ack_nxt      = 1'b0;
        frame_done_nxt    = 1'b0;

        if (tick) begin
            presc_nxt = '0;
            digit_nxt = digit + 2'd1;
        end else begin
            presc_nxt = presc + PW'(1);
        end

        // A strobe landing on the wrap edge bypasses the pending buffer entirely.
        if (frame_wrap) begin
            frame_done_nxt = 1'b1;
            if (value_valid) begin
                shadow_nxt    = value;
                pend_flag_nxt = 1'b0;
                load_ack_nxt  = 1'b1;
            end else if (pend_flag) begin
                shadow_nxt    = pending;
                pend_flag_nxt = 1'b0;
                load_ack_nxt  = 1'b1;
            end
        end else if (value_valid) begin
            pending_nxt   = value;
            pend_flag_nxt = 1'b1;
        end

        // Look ahead to the next digit/shadow so all display outputs move on one edge.
        if (tick) begin
            display_value_nxt = nibble_at(shadow_nxt, digit_nxt);
            digit_en_nxt      = lz_digit_en(shadow_nxt, digit_nxt, blank_lz);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc         <= '0;
            digit         <= 2'd0;
            shadow        <= 16'h0000;
            pending       <= 16'h0000;
            pend_flag     <= 1'b0;
            display_value <= 4'h0;
            digit_en      <= 1'b1;
            load_ack      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            presc         <= presc_nxt;
            digit         <= digit_nxt;
            shadow        <= shadow_nxt;
            pending       <= pending_nxt;
            pend_flag     <= pend_flag_nxt;
            display_value <= display_value_nxt;
            digit_en      <= digit_en_nxt;
            load_ack      <= load_ack_nxt;
            frame_done    <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (CLK_DIV=4 and CLK_DIV=1) checked every cycle
// against a time-index reference model, plus table vectors and directed corner sequences.
module tb_seven_seg_scan;

    localparam int CD_A = 4;
    localparam int CD_B = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        value_valid = 1'b0;
    logic        blank_lz = 1'b0;

    logic [3:0] a_dv, b_dv;
    logic [1:0] a_sel, b_sel;
    logic       a_en, b_en, a_ack, b_ack, a_fd, b_fd;

    always #5 clk = ~clk;

    seven_seg_scan #(.CLK_DIV(CD_A), .ZERO_NIB(4'h0)) dut_a (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .blank_lz(blank_lz),
        .display_value(a_dv), .display_select(a_sel), .digit_en(a_en),
        .load_ack(a_ack), .frame_done(a_fd)
    );

    seven_seg_scan #(.CLK_DIV(CD_B), .ZERO_NIB(4'h0)) dut_b (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .blank_lz(blank_lz),
        .display_value(b_dv), .display_select(b_sel), .digit_en(b_en),
        .load_ack(b_ack), .frame_done(b_fd)
    );

    // Reference model: position in the scan follows from the cycle count since reset.
    typedef struct packed {
        int          n;
        logic [15:0] shown;
        logic [15:0] pend;
        logic        pend_valid;
        logic        blank_slot;
        logic        ack;
        logic        fd;
    } model_t;

    model_t ma, mb;
    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt_a = 0, fd_cnt_a = 0, ack_cnt_b = 0;

    function automatic model_t model_step(model_t m, int cd, logic r, logic vv,
                                          logic [15:0] v, logic blz);
        model_t x;
        logic tk, wrap;
        x = m;
        if (r) begin
            x = '0;
            return x;
        end
        tk   = ((m.n % cd) == cd - 1);
        wrap = tk && (((m.n / cd) % 4) == 3);
        x.fd  = wrap;
        x.ack = 1'b0;
        if (wrap && vv) begin
            x.shown = v; x.pend_valid = 1'b0; x.ack = 1'b1;
        end else if (wrap && m.pend_valid) begin
            x.shown = m.pend; x.pend_valid = 1'b0; x.ack = 1'b1;
        end else if (vv) begin
            x.pend = v; x.pend_valid = 1'b1;
        end
        if (tk) x.blank_slot = blz;
        x.n = m.n + 1;
        return x;
    endfunction

    function automatic logic [1:0] exp_sel(model_t m, int cd);
        return 2'((m.n / cd) % 4);
    endfunction

    function automatic logic [3:0] exp_dv(model_t m, int cd);
        logic [15:0] s;
        s = m.shown >> (4 * ((m.n / cd) % 4));
        return s[3:0];
    endfunction

    function automatic logic exp_en(model_t m, int cd);
        int d;
        d = (m.n / cd) % 4;
        if (!m.blank_slot || d == 0) return 1'b1;
        return (m.shown >> (4 * d)) != 16'h0000;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        ma = model_step(ma, CD_A, rst, value_valid, value, blank_lz);
        mb = model_step(mb, CD_B, rst, value_valid, value, blank_lz);
        @(posedge clk);
        #1;
        chk("a_select", {14'd0, a_sel}, {14'd0, exp_sel(ma, CD_A)});
        chk("a_value",  {12'd0, a_dv},  {12'd0, exp_dv(ma, CD_A)});
        chk("a_en",     {15'd0, a_en},  {15'd0, exp_en(ma, CD_A)});
        chk("a_ack",    {15'd0, a_ack}, {15'd0, ma.ack});
        chk("a_frame",  {15'd0, a_fd},  {15'd0, ma.fd});
        chk("b_select", {14'd0, b_sel}, {14'd0, exp_sel(mb, CD_B)});
        chk("b_value",  {12'd0, b_dv},  {12'd0, exp_dv(mb, CD_B)});
        chk("b_en",     {15'd0, b_en},  {15'd0, exp_en(mb, CD_B)});
        chk("b_ack",    {15'd0, b_ack}, {15'd0, mb.ack});
        chk("b_frame",  {15'd0, b_fd},  {15'd0, mb.fd});
        if (a_ack) ack_cnt_a++;
        if (a_fd)  fd_cnt_a++;
        if (b_ack) ack_cnt_b++;
    endtask

    task automatic idle(int k);
        rst = 1'b0;
        value_valid = 1'b0;
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic strobe(logic [15:0] v);
        rst = 1'b0;
        value = v;
        value_valid = 1'b1;
        cycle();
        value_valid = 1'b0;
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        value_valid = 1'b0;
        cycle();
        rst = 1'b0;
        chk({tag, "_rst_sel"}, {14'd0, a_sel}, 16'd0);
        chk({tag, "_rst_dv"},  {12'd0, a_dv},  16'd0);
        chk({tag, "_rst_en"},  {15'd0, a_en},  16'd1);
        chk({tag, "_rst_ack"}, {15'd0, a_ack}, 16'd0);
        chk({tag, "_rst_fd"},  {15'd0, a_fd},  16'd0);
        chk({tag, "_rst_bsel"}, {14'd0, b_sel}, 16'd0);
        chk({tag, "_rst_bdv"},  {12'd0, b_dv},  16'd0);
    endtask

    task automatic wait_wrap_a(string tag);
        int k;
        k = 0;
        value_valid = 1'b0;
        while (!a_fd && k < 80) begin
            cycle();
            k++;
        end
        if (!a_fd) chk({tag, "_wrap_timeout"}, 16'd0, 16'd1);
    endtask

    // Expected display per select: dv[d] is the nibble shown on select d, en[d] its enable.
    typedef struct packed {
        logic [15:0]     val;
        logic            blz;
        logic [3:0][3:0] dv;
        logic [3:0]      en;
    } vec_t;

    vec_t vecs [7];

    task automatic apply_vec(int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        blank_lz = vecs[i].blz;
        strobe(vecs[i].val);
        wait_wrap_a(tag);
        chk({tag, "_ack_at_wrap"}, {15'd0, a_ack}, 16'd1);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) idle(CD_A);
            chk($sformatf("%s_sel%0d", tag, d), {14'd0, a_sel}, 16'(d));
            chk($sformatf("%s_dv%0d", tag, d), {12'd0, a_dv}, {12'd0, vecs[i].dv[d]});
            chk($sformatf("%s_en%0d", tag, d), {15'd0, a_en}, {15'd0, vecs[i].en[d]});
        end
    endtask

    initial begin
        ma = '0;
        mb = '0;
        vecs[0] = '{val: 16'hA5C3, blz: 1'b0, dv: {4'hA, 4'h5, 4'hC, 4'h3}, en: 4'b1111};
        vecs[1] = '{val: 16'h0070, blz: 1'b1, dv: {4'h0, 4'h0, 4'h7, 4'h0}, en: 4'b0011};
        vecs[2] = '{val: 16'h0000, blz: 1'b1, dv: {4'h0, 4'h0, 4'h0, 4'h0}, en: 4'b0001};
        vecs[3] = '{val: 16'h0070, blz: 1'b0, dv: {4'h0, 4'h0, 4'h7, 4'h0}, en: 4'b1111};
        vecs[4] = '{val: 16'h1000, blz: 1'b1, dv: {4'h1, 4'h0, 4'h0, 4'h0}, en: 4'b1111};
        vecs[5] = '{val: 16'h0001, blz: 1'b1, dv: {4'h0, 4'h0, 4'h0, 4'h1}, en: 4'b0001};
        vecs[6] = '{val: 16'h0F00, blz: 1'b1, dv: {4'h0, 4'hF, 4'h0, 4'h0}, en: 4'b0111};

        // Reset then idle: one frame_done every 16 cycles.
        do_reset("t1");
        fd_cnt_a = 0;
        idle(64);
        chk("t1_frame_count", 16'(fd_cnt_a), 16'd4);

        // Mid-frame strobe (digit 1) followed by the rest of the vector table.
        do_reset("t2");
        idle(5);
        chk("t2_mid_sel", {14'd0, a_sel}, 16'd1);
        for (int i = 0; i < 7; i++) apply_vec(i);

        // Two strobes in one frame: the later one wins, a single load.
        blank_lz = 1'b0;
        do_reset("t3");
        idle(2);
        ack_cnt_a = 0;
        strobe(16'h1111);
        idle(2);
        strobe(16'h2222);
        wait_wrap_a("t3");
        chk("t3_ack_at_wrap", {15'd0, a_ack}, 16'd1);
        chk("t3_dv0", {12'd0, a_dv}, 16'h2);
        idle(32);
        chk("t3_ack_count", 16'(ack_cnt_a), 16'd1);

        // Strobe exactly on the boundary cycle goes straight to the display.
        do_reset("t4");
        idle(15);
        strobe(16'h00F0);
        chk("t4_ack", {15'd0, a_ack}, 16'd1);
        chk("t4_fd",  {15'd0, a_fd},  16'd1);
        chk("t4_dv0", {12'd0, a_dv},  16'h0);
        ack_cnt_a = 0;
        idle(4);
        chk("t4_dv1", {12'd0, a_dv}, 16'hF);
        idle(28);
        chk("t4_no_reload", 16'(ack_cnt_a), 16'd0);

        // Reset at digit 2 with a pending value: the value must never appear.
        do_reset("t6");
        idle(8);
        strobe(16'h1234);
        idle(1);
        chk("t6_sel_before", {14'd0, a_sel}, 16'd2);
        do_reset("t6b");
        ack_cnt_a = 0;
        idle(40);
        chk("t6_no_load", 16'(ack_cnt_a), 16'd0);
        chk("t6_dv_zero", {12'd0, a_dv}, 16'd0);

        // CLK_DIV=1: digit advances every cycle; same reset-drops-pending check.
        do_reset("t6c");
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk($sformatf("t6_b_sel_step%0d", k), {14'd0, b_sel}, 16'(k % 4));
        end
        do_reset("t6d");
        idle(1);
        strobe(16'h4321);
        chk("t6_b_sel2", {14'd0, b_sel}, 16'd2);
        do_reset("t6e");
        ack_cnt_b = 0;
        idle(12);
        chk("t6_b_no_load", 16'(ack_cnt_b), 16'd0);

        // Randomized traffic checked against the model every cycle.
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            value_valid = ($urandom_range(0, 9) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
            if ($urandom_range(0, 4) == 0) value = value & 16'h000F;
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
